// File: rtl/i2cmb_cmd_sequencer.sv
// rtl/i2cmb_cmd_sequencer.sv - single-byte I2C transfer sequencer driving an I2CMB core over Wishbone
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   transfer request handshake
//   req_bus_i/addr/rw/wdata   bus id, 7-bit slave address, direction, write byte
//   rsp_valid_o               one-cycle completion pulse
//   rsp_status_o/rsp_rdata_o  00 OK, 01 NAK, 10 arbitration lost/error, 11 timeout; read byte
//   wb_*                      Wishbone master towards CSR(0)/DPR(1)/CMDR(2)
module i2cmb_cmd_sequencer #(
  parameter int         POLL_LIMIT = 1023,
  parameter logic [7:0] CSR_ENABLE = 8'hC0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [3:0] req_bus_i,
  input  logic [6:0] req_addr_i,
  input  logic       req_rw_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [1:0] rsp_status_o,
  output logic [7:0] rsp_rdata_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [1:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  localparam int CW = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(POLL_LIMIT);

  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;

  localparam logic [7:0] CMD_WRITE   = 8'd1;
  localparam logic [7:0] CMD_READ_NK = 8'd3;
  localparam logic [7:0] CMD_START   = 8'd4;
  localparam logic [7:0] CMD_STOP    = 8'd5;
  localparam logic [7:0] CMD_SET_BUS = 8'd6;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_NAK  = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;
  localparam logic [1:0] ST_TOUT = 2'b11;

  typedef enum logic [3:0] {
    IDLE, ENABLE, SET_BUS, START, ADDR, DATA, READ_DPR, STOP, WAIT, RESP
  } state_t;

  state_t          state_q, state_d, ret_q, ret_d;
  logic            step_q, step_d;
  logic            cyc_q, cyc_d, we_q, we_d;
  logic [1:0]      adr_q, adr_d;
  logic [7:0]      dat_q, dat_d;
  logic            enabled_q, enabled_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [3:0]      bus_q, bus_d;
  logic [6:0]      addr_q, addr_d;
  logic            rw_q, rw_d;
  logic [7:0]      wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]      pend_q, pend_d, rsp_status_q, rsp_status_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;
  logic            alive_q;

  // Per-state access description; the issue logic below turns it into a bus cycle.
  logic            acc_we;
  logic [1:0]      acc_adr;
  logic [7:0]      acc_dat;
  logic            done;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      ret_q        <= IDLE;
      step_q       <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 2'd0;
      dat_q        <= 8'd0;
      enabled_q    <= 1'b0;
      cnt_q        <= '0;
      bus_q        <= 4'd0;
      addr_q       <= 7'd0;
      rw_q         <= 1'b0;
      wdata_q      <= 8'd0;
      rdata_q      <= 8'd0;
      pend_q       <= ST_OK;
      rsp_status_q <= ST_OK;
      rsp_rdata_q  <= 8'd0;
      alive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      step_q       <= step_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      enabled_q    <= enabled_d;
      cnt_q        <= cnt_d;
      bus_q        <= bus_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      pend_q       <= pend_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
      alive_q      <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    step_d       = step_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    enabled_d    = enabled_q;
    cnt_d        = cnt_q;
    bus_d        = bus_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    pend_d       = pend_q;
    rsp_status_d = rsp_status_q;
    rsp_rdata_d  = rsp_rdata_q;
    acc_we       = 1'b1;
    acc_adr      = ADR_CMDR;
    acc_dat      = 8'd0;
    done         = cyc_q & wb_ack_i;
    cnt_inc      = cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (req_valid_i && alive_q) begin
          bus_d   = req_bus_i;
          addr_d  = req_addr_i;
          rw_d    = req_rw_i;
          wdata_d = req_wdata_i;
          pend_d  = ST_OK;
          step_d  = 1'b0;
          state_d = enabled_q ? SET_BUS : ENABLE;
        end
      end
      ENABLE: begin
        acc_adr = ADR_CSR;
        acc_dat = CSR_ENABLE;
        if (done) begin
          enabled_d = 1'b1;
          state_d   = SET_BUS;
        end
      end
      SET_BUS: begin
        if (!step_q) begin
          acc_adr = ADR_DPR;
          acc_dat = {4'b0, bus_q};
          if (done) step_d = 1'b1;
        end else begin
          acc_dat = CMD_SET_BUS;
          if (done) begin
            step_d  = 1'b0;
            ret_d   = START;
            state_d = WAIT;
          end
        end
      end
      START: begin
        acc_dat = CMD_START;
        if (done) begin
          ret_d   = ADDR;
          state_d = WAIT;
        end
      end
      ADDR: begin
        if (!step_q) begin
          acc_adr = ADR_DPR;
          acc_dat = {addr_q, rw_q};
          if (done) step_d = 1'b1;
        end else begin
          acc_dat = CMD_WRITE;
          if (done) begin
            step_d  = 1'b0;
            ret_d   = DATA;
            state_d = WAIT;
          end
        end
      end
      DATA: begin
        if (rw_q) begin
          acc_dat = CMD_READ_NK;
          if (done) begin
            ret_d   = READ_DPR;
            state_d = WAIT;
          end
        end else if (!step_q) begin
          acc_adr = ADR_DPR;
          acc_dat = wdata_q;
          if (done) step_d = 1'b1;
        end else begin
          acc_dat = CMD_WRITE;
          if (done) begin
            step_d  = 1'b0;
            ret_d   = STOP;
            state_d = WAIT;
          end
        end
      end
      READ_DPR: begin
        acc_we  = 1'b0;
        acc_adr = ADR_DPR;
        if (done) begin
          rdata_d = wb_dat_i;
          state_d = STOP;
        end
      end
      STOP: begin
        acc_dat = CMD_STOP;
        if (done) begin
          ret_d   = RESP;
          state_d = WAIT;
        end
      end
      WAIT: begin
        acc_we = 1'b0;
        if (done) begin
          rsp_rdata_d = rdata_q;
          if (wb_dat_i[5] || wb_dat_i[4]) begin
            // Arbitration lost or bus error: the core owns no bus, so no stop.
            rsp_status_d = ST_ERR;
            state_d      = RESP;
          end else if (wb_dat_i[6]) begin
            // NAK still needs a stop unless this was the stop's own wait.
            if (ret_q == RESP) begin
              rsp_status_d = ST_NAK;
              state_d      = RESP;
            end else begin
              pend_d  = ST_NAK;
              state_d = STOP;
            end
          end else if (wb_dat_i[7]) begin
            state_d = ret_q;
            if (ret_q == RESP) rsp_status_d = pend_q;
          end else if (cnt_inc == LIMIT) begin
            rsp_status_d = ST_TOUT;
            state_d      = RESP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Launching only while cyc is low guarantees one idle cycle between accesses.
    if (state_q != IDLE && state_q != RESP && !cyc_q) begin
      cyc_d = 1'b1;
      we_d  = acc_we;
      adr_d = acc_adr;
      dat_d = acc_we ? acc_dat : 8'd0;
      if (acc_we && acc_adr == ADR_CMDR) cnt_d = '0;
    end
    if (done) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = 2'd0;
      dat_d = 8'd0;
    end
  end

  assign req_ready_o  = (state_q == IDLE) && alive_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_status_o = rsp_status_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// tb/tb_i2cmb_cmd_sequencer.sv - directed scoreboard bench for i2cmb_cmd_sequencer
module tb_i2cmb_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_bus = 4'd0;
  logic [6:0] req_addr = 7'd0;
  logic       req_rw = 1'b0;
  logic [7:0] req_wdata = 8'd0;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [7:0] rsp_rdata;
  logic       wb_cyc, wb_stb, wb_we;
  logic [1:0] wb_adr;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = 8'd0;
  logic       wb_ack = 1'b0;

  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
    logic [7:0] rd;
  } acc_t;

  typedef struct {
    logic [1:0] st;
    logic [7:0] rd;
    logic       chk_rd;
  } rsp_t;

  acc_t expq[$];
  rsp_t rspq[$];
  int   vecs = 0;
  int   fails = 0;
  int   rsp_count = 0;
  logic hold_ack = 1'b0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  i2cmb_cmd_sequencer #(.POLL_LIMIT(4), .CSR_ENABLE(8'hC0)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_bus_i(req_bus), .req_addr_i(req_addr), .req_rw_i(req_rw), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_status_o(rsp_status), .rsp_rdata_o(rsp_rdata),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void pw(input logic [1:0] a, input logic [7:0] d);
    acc_t e;
    e.we = 1'b1; e.adr = a; e.dat = d; e.rd = 8'h00;
    expq.push_back(e);
  endfunction

  function automatic void pr(input logic [1:0] a, input logic [7:0] rd);
    acc_t e;
    e.we = 1'b0; e.adr = a; e.dat = 8'h00; e.rd = rd;
    expq.push_back(e);
  endfunction

  // Command write followed by a single CMDR poll that reports DON.
  function automatic void pcmd(input logic [7:0] c);
    pw(2'd2, c);
    pr(2'd2, 8'h80);
  endfunction

  // Wishbone slave: every access is checked against the head of the expected-access queue.
  initial begin : slave
    acc_t e;
    forever begin
      @(negedge clk);
      if (wb_ack) begin
        wb_ack = 1'b0;
      end else if (wb_cyc && wb_stb && !hold_ack) begin
        check("acc_expected", expq.size() > 0, 1);
        wb_dat_i = 8'h80;
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("acc_we", wb_we, e.we);
          check("acc_adr", wb_adr, e.adr);
          if (e.we) check("acc_dat", wb_dat_o, e.dat);
          wb_dat_i = e.rd;
        end
        wb_ack = 1'b1;
      end
    end
  end

  // Response monitor: one pulse per request, compared against the response queue.
  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_count++;
        check("rsp_one_cycle", prev_valid, 0);
        check("rsp_outstanding", rspq.size(), 1);
        if (rspq.size() > 0) begin
          r = rspq.pop_front();
          check("rsp_status", rsp_status, r.st);
          if (r.chk_rd) check("rsp_rdata", rsp_rdata, r.rd);
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic issue(input logic [3:0] b, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    @(negedge clk);
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    check("req_ready_before", req_ready, 1);
    req_valid = 1'b1; req_bus = b; req_addr = a; req_rw = rw; req_wdata = wd;
    @(posedge clk);
    #1;
    // Scrambled fields after acceptance must not leak into the transfer.
    req_valid = 1'b0; req_bus = ~b; req_addr = ~a; req_rw = ~rw; req_wdata = ~wd;
  endtask

  task automatic do_req(input logic [3:0] b, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                        input logic [1:0] st, input logic [7:0] rd, input logic chk);
    rsp_t r;
    logic got;
    got = 1'b0;
    r.st = st; r.rd = rd; r.chk_rd = chk;
    rspq.push_back(r);
    issue(b, a, rw, wd);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("rsp_seen", got, 1);
    if (got) begin
      check("ready_in_resp", req_ready, 0);
      @(negedge clk);
      check("ready_after_resp", req_ready, 1);
    end
    check("acc_queue_drained", expq.size(), 0);
  endtask

  initial begin : main
    int n0;
    logic seen;
    #12;
    check("rst_cyc", wb_cyc, 0);
    check("rst_stb", wb_stb, 0);
    check("rst_we", wb_we, 0);
    check("rst_adr", wb_adr, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", req_ready, 0);
    @(negedge clk);
    check("ready_after_edge", req_ready, 1);

    // First write after reset: enables the core.
    pw(2'd0, 8'hC0); pw(2'd1, 8'h02); pcmd(8'h06); pcmd(8'h04);
    pw(2'd1, 8'h44); pcmd(8'h01); pw(2'd1, 8'h5A); pcmd(8'h01); pcmd(8'h05);
    do_req(4'd2, 7'h22, 1'b0, 8'h5A, 2'b00, 8'h00, 1'b0);

    // Read; three empty polls per wait exercise the counter clear on each command.
    pw(2'd1, 8'h02);
    pw(2'd2, 8'h06); pr(2'd2, 8'h00); pr(2'd2, 8'h00); pr(2'd2, 8'h00); pr(2'd2, 8'h80);
    pw(2'd2, 8'h04); pr(2'd2, 8'h00); pr(2'd2, 8'h00); pr(2'd2, 8'h00); pr(2'd2, 8'h80);
    pw(2'd1, 8'h45); pcmd(8'h01); pcmd(8'h03); pr(2'd1, 8'hA5); pcmd(8'h05);
    do_req(4'd2, 7'h22, 1'b1, 8'h00, 2'b00, 8'hA5, 1'b1);

    // Address NAK: no data phase, stop still issued.
    pw(2'd1, 8'h01); pw(2'd2, 8'h06); pr(2'd2, 8'h00); pr(2'd2, 8'h80); pcmd(8'h04);
    pw(2'd1, 8'h20); pw(2'd2, 8'h01); pr(2'd2, 8'h40); pcmd(8'h05);
    do_req(4'd1, 7'h10, 1'b0, 8'h33, 2'b01, 8'h00, 1'b0);

    // Arbitration lost after start: no stop.
    pw(2'd1, 8'h03); pcmd(8'h06); pw(2'd2, 8'h04); pr(2'd2, 8'h20);
    do_req(4'd3, 7'h55, 1'b1, 8'h00, 2'b10, 8'h00, 1'b0);

    // Timeout after exactly POLL_LIMIT empty polls.
    pw(2'd1, 8'h00); pw(2'd2, 8'h06);
    for (int i = 0; i < 4; i++) pr(2'd2, 8'h00);
    do_req(4'd0, 7'h01, 1'b0, 8'h00, 2'b11, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    check("status_hold", rsp_status, 2'b11);
    check("no_extra_access", expq.size(), 0);

    // Reset during an unacknowledged access.
    hold_ack = 1'b1;
    n0 = rsp_count;
    issue(4'd2, 7'h22, 1'b0, 8'h5A);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wb_stb) begin
        seen = 1'b1;
        break;
      end
    end
    check("stb_before_reset", seen, 1);
    rst_n = 1'b0;
    #1;
    check("abort_cyc", wb_cyc, 0);
    check("abort_stb", wb_stb, 0);
    check("abort_ready", req_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_rsp", rsp_count, n0);

    // Enabled flag was cleared by reset, so CSR is written again.
    pw(2'd0, 8'hC0); pw(2'd1, 8'h05); pcmd(8'h06); pcmd(8'h04);
    pw(2'd1, 8'h78); pcmd(8'h01); pw(2'd1, 8'hC3); pcmd(8'h01); pcmd(8'h05);
    do_req(4'd5, 7'h3C, 1'b0, 8'hC3, 2'b00, 8'h00, 1'b0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
